// File: rtl/ysyx_25040129_axil_master.sv
// AXI4-Lite master bridging a simple CPU load/store request/response port onto
// separate AR/R and AW/W/B channels, one transaction at a time.
module ysyx_25040129_axil_master #(
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_wdata,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,

  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,

  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [1:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    WR   = 3'd3,
    B    = 3'd4,
    RSP  = 3'd5
  } state_t;

  state_t state, state_next;

  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic        wen_q;
  logic [31:0] wdata_q;
  logic        aw_done;
  logic        w_done;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        accept;
  logic        misaligned;
  logic        aw_fire;
  logic        w_fire;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  assign arvalid = (state == AR);
  assign araddr  = {addr_q[31:2], 2'b00};
  assign rready  = (state == R);

  assign awvalid = (state == WR) && !aw_done;
  assign wvalid  = (state == WR) && !w_done;
  assign awaddr  = addr_q;
  assign wdata   = wdata_q;
  // The memory responder decodes the size code directly, not a byte mask.
  assign wstrb   = size_q;
  assign bready  = (state == B);

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  assign rsp_valid = (state == RSP);
  assign rsp_rdata = wen_q ? 32'd0 : rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    misaligned = 1'b0;
    if (ALIGN_CHECK != 0) begin
      case (req_size)
        2'b00:   misaligned = 1'b1;
        2'b10:   misaligned = req_addr[0];
        2'b11:   misaligned = (req_addr[1:0] != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_q[1:0])
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_q[1] ? rdata[31:16] : rdata[15:0];
    load_ext = rdata;
    case (size_q)
      2'b01:   load_ext = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b10:   load_ext = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_ext = rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)   state_next = RSP;
          else if (req_wen) state_next = WR;
          else              state_next = AR;
        end
      end
      AR:  if (arready) state_next = R;
      R:   if (rvalid)  state_next = RSP;
      // Either channel may finish first; move on once both have been seen.
      WR:  if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = B;
      B:   if (bvalid)    state_next = RSP;
      RSP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= 32'd0;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      wen_q       <= 1'b0;
      wdata_q     <= 32'd0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        sext_q  <= req_sext;
        wen_q   <= req_wen;
        wdata_q <= req_wdata;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (misaligned) begin
          rsp_rdata_q <= 32'd0;
          rsp_err_q   <= 1'b1;
        end
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if (state == R && rvalid) begin
        rsp_rdata_q <= load_ext;
        rsp_err_q   <= (rresp != 2'b00);
      end
      if (state == B && bvalid) begin
        rsp_rdata_q <= 32'd0;
        rsp_err_q   <= (bresp != 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_axil_master.sv
// Directed bench for the AXI4-Lite master: the bench plays the memory responder
// by hand and checks every channel at the negative clock edge.
module tb_ysyx_25040129_axil_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [1:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks = 0;
  int errors = 0;

  ysyx_25040129_axil_master #(.ALIGN_CHECK(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_sext(req_sext),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wen, input logic [31:0] addr,
                               input logic [1:0] size, input logic sext,
                               input logic [31:0] wd);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_size  = size;
    req_sext  = sext;
    req_wdata = wd;
  endtask

  task automatic clearBus();
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    rsp_ready = 1'b0;
  endtask

  // Zero-wait load; the response is then held for holdCycles before rsp_ready.
  task automatic runLoad(input string tag, input logic [31:0] addr,
                         input logic [1:0] size, input logic sext,
                         input logic [31:0] rd, input logic [1:0] rr,
                         input logic [31:0] expRdata, input logic expErr,
                         input int holdCycles);
    applyStimulus(1'b0, addr, size, sext, 32'd0);
    arready = 1'b1; rvalid = 1'b1; rdata = rd; rresp = rr;
    checkOutput({tag, ".req_ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    checkOutput({tag, ".arvalid@T1"}, arvalid, 1);
    checkOutput({tag, ".araddr"}, araddr, {addr[31:2], 2'b00});
    checkOutput({tag, ".rready@T1"}, rready, 0);
    tick();
    checkOutput({tag, ".rready@T2"}, rready, 1);
    checkOutput({tag, ".arvalid@T2"}, arvalid, 0);
    tick();
    clearBus();
    checkOutput({tag, ".rsp_valid@T3"}, rsp_valid, 1);
    checkOutput({tag, ".rsp_rdata"}, rsp_rdata, expRdata);
    checkOutput({tag, ".rsp_err"}, rsp_err, expErr);
    for (int i = 0; i < holdCycles; i++) begin
      tick();
      checkOutput({tag, ".hold.rsp_valid"}, rsp_valid, 1);
      checkOutput({tag, ".hold.rsp_rdata"}, rsp_rdata, expRdata);
      checkOutput({tag, ".hold.req_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput({tag, ".idle.req_ready"}, req_ready, 1);
    checkOutput({tag, ".idle.rsp_valid"}, rsp_valid, 0);
  endtask

  task automatic runMisaligned(input string tag, input logic wen,
                               input logic [31:0] addr, input logic [1:0] size);
    applyStimulus(wen, addr, size, 1'b0, 32'hCAFE_F00D);
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    tick();
    req_valid = 1'b0;
    clearBus();
    checkOutput({tag, ".rsp_valid"}, rsp_valid, 1);
    checkOutput({tag, ".rsp_err"}, rsp_err, 1);
    checkOutput({tag, ".rsp_rdata"}, rsp_rdata, 0);
    checkOutput({tag, ".no_valid"}, {arvalid, awvalid, wvalid}, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput({tag, ".idle"}, req_ready, 1);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    applyStimulus(1'b0, 32'd0, 2'b11, 1'b0, 32'd0);
    req_valid = 1'b0;
    clearBus();
    #1;
    checkOutput("reset.req_ready", req_ready, 1);
    checkOutput("reset.valids", {arvalid, awvalid, wvalid, rsp_valid}, 0);
    checkOutput("reset.readies", {rready, bready}, 0);
    checkOutput("reset.rsp_rdata", rsp_rdata, 0);
    checkOutput("reset.rsp_err", rsp_err, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    runLoad("lw", 32'h8000_0004, 2'b11, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0, 0);
    runLoad("lb_sext", 32'h8000_0003, 2'b01, 1'b1, 32'h8012_3456, 2'b00, 32'hFFFF_FF80, 1'b0, 0);
    runLoad("lbu", 32'h8000_0003, 2'b01, 1'b0, 32'h8012_3456, 2'b00, 32'h0000_0080, 1'b0, 0);
    runLoad("lh_sext", 32'h8000_0002, 2'b10, 1'b1, 32'h9ABC_1234, 2'b00, 32'hFFFF_9ABC, 1'b0, 0);
    runLoad("lhu_lo", 32'h8000_0000, 2'b10, 1'b0, 32'h9ABC_F234, 2'b00, 32'h0000_F234, 1'b0, 0);
    runLoad("lb_lane1", 32'h8000_0001, 2'b01, 1'b1, 32'h0000_7F00, 2'b00, 32'h0000_007F, 1'b0, 0);
    runLoad("lw_slverr", 32'h8000_0010, 2'b11, 1'b0, 32'h1111_2222, 2'b10, 32'h1111_2222, 1'b1, 0);
    runLoad("lw_hold5", 32'h8000_0008, 2'b11, 1'b0, 32'h5555_AAAA, 2'b00, 32'h5555_AAAA, 1'b0, 5);

    // Store half with AW accepted three cycles before W.
    applyStimulus(1'b1, 32'h8000_0002, 2'b10, 1'b0, 32'h0000_1234);
    tick();
    req_valid = 1'b0;
    checkOutput("sh.awvalid@T1", awvalid, 1);
    checkOutput("sh.wvalid@T1", wvalid, 1);
    checkOutput("sh.awaddr", awaddr, 32'h8000_0002);
    checkOutput("sh.wdata", wdata, 32'h0000_1234);
    checkOutput("sh.wstrb@T1", wstrb, 2'b10);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput("sh.awvalid_dropped", awvalid, 0);
      checkOutput("sh.wvalid_held", wvalid, 1);
      checkOutput("sh.wstrb_held", wstrb, 2'b10);
      checkOutput("sh.bready_early", bready, 0);
      tick();
    end
    wready = 1'b1;
    checkOutput("sh.wvalid@wready", wvalid, 1);
    tick();
    wready = 1'b0;
    checkOutput("sh.wvalid_dropped", wvalid, 0);
    checkOutput("sh.bready", bready, 1);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    clearBus();
    checkOutput("sh.rsp_valid", rsp_valid, 1);
    checkOutput("sh.rsp_err", rsp_err, 0);
    checkOutput("sh.rsp_rdata", rsp_rdata, 0);
    checkOutput("sh.bready_off", bready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("sh.idle", req_ready, 1);

    // Store word with both handshakes in the same cycle and an error response.
    applyStimulus(1'b1, 32'h8000_0008, 2'b11, 1'b0, 32'hA5A5_5A5A);
    awready = 1'b1; wready = 1'b1;
    tick();
    req_valid = 1'b0;
    checkOutput("sw.valids", {awvalid, wvalid}, 2'b11);
    checkOutput("sw.wstrb", wstrb, 2'b11);
    tick();
    awready = 1'b0; wready = 1'b0;
    checkOutput("sw.bready", bready, 1);
    checkOutput("sw.valids_off", {awvalid, wvalid}, 0);
    bvalid = 1'b1; bresp = 2'b10;
    tick();
    clearBus();
    checkOutput("sw.rsp_err", rsp_err, 1);
    checkOutput("sw.rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    runMisaligned("mis_lw", 1'b0, 32'h8000_0001, 2'b11);
    runMisaligned("mis_lh", 1'b0, 32'h8000_0003, 2'b10);
    runMisaligned("mis_sz0", 1'b0, 32'h8000_0000, 2'b00);
    runMisaligned("mis_sw", 1'b1, 32'h8000_0002, 2'b11);

    // Reset while waiting in R, then a clean load.
    applyStimulus(1'b0, 32'h8000_0000, 2'b11, 1'b0, 32'd0);
    arready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    arready = 1'b0;
    checkOutput("rstR.rready_before", rready, 1);
    rst = 1'b0;
    #1;
    checkOutput("rstR.rready", rready, 0);
    checkOutput("rstR.valids", {arvalid, awvalid, wvalid, rsp_valid, bready}, 0);
    checkOutput("rstR.req_ready", req_ready, 1);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rstR.after_release", req_ready, 1);
    runLoad("post_rst", 32'h8000_0000, 2'b11, 1'b0, 32'h1122_3344, 2'b00, 32'h1122_3344, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach its end");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/ysyx_25040129_axil_master.md
YSYX_25040129_AXIL_MASTER -- requirements
Module: ysyx_25040129_axil_master

Interface
REQ-001 The block SHALL have parameter ALIGN_CHECK, default 1, meaning that a misaligned request is answered with an error and no bus transaction is issued.
REQ-002 The block SHALL have port clk, input, width 1: the single clock; all sequential logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, width 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req_valid, input, width 1: the CPU-side request is valid.
REQ-005 The block SHALL have port req_ready, output, width 1: the block can accept a request.
REQ-006 The block SHALL have port req_wen, input, width 1: 1 selects store, 0 selects load.
REQ-007 The block SHALL have port req_addr, input, width 32: byte address.
REQ-008 The block SHALL have port req_size, input, width 2: access size; 01 = byte, 10 = half, 11 = word, 00 is illegal.
REQ-009 The block SHALL have port req_sext, input, width 1: load sign-extend enable.
REQ-010 The block SHALL have port req_wdata, input, width 32: store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, width 1, and port rsp_ready, input, width 1: the response handshake.
REQ-012 The block SHALL have port rsp_rdata, output, width 32: extended load data.
REQ-013 The block SHALL have port rsp_err, output, width 1: the transaction failed.
REQ-014 The block SHALL have the AXI4-Lite master ports araddr[32], arvalid, arready, rdata[32], rresp[2], rvalid, rready, awaddr[32], awvalid, awready, wdata[32], wstrb[2], wvalid, wready, bresp[2], bvalid and bready, with standard directions.
REQ-015 wstrb SHALL carry the size code (01/10/11) and not a byte mask, matching the team memory responder.

Function
REQ-016 The block SHALL implement the states IDLE, AR, R, WR, B and RSP, one transaction at a time.
REQ-017 req_ready SHALL equal (state == IDLE); a request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-018 On acceptance, the block SHALL latch addr, size, sext, wen and wdata into registers; the bus outputs are driven only from these latched registers.
REQ-019 Load acceptance SHALL cause the transition IDLE to AR; arvalid is 1 from the next cycle, and araddr = {addr[31:2], 2'b00}.
REQ-020 In AR, arvalid and araddr SHALL be held stable until arready; on arready the state moves to R.
REQ-021 In R, rready SHALL be 1; on rvalid the block captures rdata and rresp, and the state moves to RSP.
REQ-022 Load extraction: byte = rdata >> (8*addr[1:0]), bits [7:0]; half = rdata >> (16*addr[1]), bits [15:0]; word = rdata.
REQ-023 The extracted value SHALL be sign-extended when sext is 1 and zero-extended otherwise, to 32 bits.
REQ-024 Store acceptance SHALL cause the transition IDLE to WR; awvalid and wvalid are both 1 from the next cycle, with awaddr = addr unmodified, wdata = wdata and wstrb = size.
REQ-025 The AW and W channels SHALL be tracked independently by aw_done and w_done flags; each valid deasserts the cycle after its own handshake.
REQ-026 When aw_done and w_done are both set, or both handshakes complete in the same cycle, the state SHALL move from WR to B.
REQ-027 In B, bready SHALL be 1; on bvalid the block captures bresp, and the state moves to RSP.
REQ-028 In RSP, rsp_valid SHALL be 1, with rsp_rdata and rsp_err held stable; on rsp_ready the state moves to IDLE, so a new request can be accepted on the following cycle.
REQ-029 rsp_err SHALL be 1 when the captured resp is not 00; rsp_rdata is 0 for stores.
REQ-030 When ALIGN_CHECK = 1, a request SHALL be misaligned if it is a half access with addr[0] = 1, a word access with addr[1:0] not 00, or has size 00.
REQ-031 A misaligned request SHALL go IDLE to RSP directly with rsp_err = 1, rsp_rdata = 0, and no valid asserted.
REQ-032 Minimum load latency SHALL be: accept at T, arvalid at T+1, rready at T+2, rsp_valid at T+3 given zero-wait responder handshakes.
REQ-033 Each valid signal SHALL never deassert before its handshake, and its payload SHALL never change while the valid is high.
REQ-034 The ready outputs (rready, bready) SHALL be 0 outside states R and B respectively.

Reset
REQ-035 When rst is low, the block SHALL asynchronously force state IDLE, with arvalid, awvalid, wvalid, rready, bready and rsp_valid at 0, rsp_rdata = 0, rsp_err = 0, and aw_done and w_done cleared.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction; after release, req_ready is 1 on the first clock edge.

Verification
REQ-037 Scenario: load word at addr 0x80000004, where the responder returns 0xDEADBEEF with rresp 00 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid at T+3.
REQ-038 Scenario: load byte with sext at addr 0x80000003, where rdata = 0x80123456 -> rsp_rdata = 0xFFFFFF80; the same load without sext -> 0x00000080.
REQ-039 Scenario: store half of 0x1234 at 0x80000002, where the responder raises awready 3 cycles before wready -> awvalid drops first, wvalid stays high until wready, then bready is asserted; bresp 00 -> rsp_err = 0; wstrb = 10 throughout.
REQ-040 Scenario: load word at 0x80000001 with ALIGN_CHECK = 1 -> no arvalid is ever asserted, and rsp_valid is 1 with rsp_err = 1 one cycle after acceptance.
REQ-041 Scenario: rsp_ready is held 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; rsp_ready rises -> IDLE on the next cycle.
REQ-042 Scenario: rst is pulled low while in state R with rvalid pending -> all valids and readies drop immediately, and req_ready = 1 after release; a new load of 0x80000000 then completes normally.
